branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 120 ++++++++++++
 tb/tb_branch_predictor.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
//==============================================================================
// Module      : branch_predictor
// Description : Direct-mapped branch target buffer with 2-bit saturating
//               direction counters, combinational lookup and strobed update.
//               Define BP_STATS_EN to add branch / misprediction counters.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module branch_predictor #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispred
`endif
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = 30 - INDEX_BITS;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    // Lookup path: purely combinational from the registered table
    logic [INDEX_BITS-1:0] lk_idx_w;
    logic [TAG_W-1:0]      lk_tag_w;
    logic                  lk_hit_w;

    assign lk_idx_w    = if_pc[INDEX_BITS+1:2];
    assign lk_tag_w    = if_pc[31:INDEX_BITS+2];
    assign lk_hit_w    = valid_q[lk_idx_w] && (tag_q[lk_idx_w] == lk_tag_w);
    assign pred_taken  = lk_hit_w && ctr_q[lk_idx_w][1];
    assign pred_target = pred_taken ? target_q[lk_idx_w] : (if_pc + 32'd4);

    // Update path: compute the replacement contents of the single indexed entry
    logic [INDEX_BITS-1:0] up_idx_w;
    logic [TAG_W-1:0]      up_tag_w;
    logic                  up_hit_w;
    logic                  up_we_w;
    logic [31:0]           target_d;
    logic [1:0]            ctr_d;

    assign up_idx_w = upd_pc[INDEX_BITS+1:2];
    assign up_tag_w = upd_pc[31:INDEX_BITS+2];
    assign up_hit_w = valid_q[up_idx_w] && (tag_q[up_idx_w] == up_tag_w);
    // A not-taken miss never allocates, so only hits or taken branches write
    assign up_we_w  = upd_valid && (up_hit_w || upd_taken);

    always_comb begin
        target_d = target_q[up_idx_w];
        ctr_d    = 2'b10;
        if (upd_taken) begin
            target_d = upd_target;
        end
        if (up_hit_w) begin
            if (upd_taken) begin
                ctr_d = (ctr_q[up_idx_w] == 2'b11) ? 2'b11 : ctr_q[up_idx_w] + 2'b01;
            end else begin
                ctr_d = (ctr_q[up_idx_w] == 2'b00) ? 2'b00 : ctr_q[up_idx_w] - 2'b01;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (up_we_w) begin
            valid_q[up_idx_w]  <= 1'b1;
            tag_q[up_idx_w]    <= up_tag_w;
            target_q[up_idx_w] <= target_d;
            ctr_q[up_idx_w]    <= ctr_d;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] branches_q;
    logic [31:0] mispred_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            branches_q <= '0;
            mispred_q  <= '0;
        end else if (upd_valid) begin
            branches_q <= branches_q + 32'd1;
            if (upd_pred != upd_taken) begin
                mispred_q <= mispred_q + 32'd1;
            end
        end
    end

    assign stat_branches = branches_q;
    assign stat_mispred  = mispred_q;
`endif

    // Byte-offset bits and (without statistics) upd_pred carry no information
    logic unused_w;
    assign unused_w = ^{upd_pred, if_pc[1:0], upd_pc[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
//==============================================================================
// Module      : tb_branch_predictor
// Description : Self-checking bench for branch_predictor (directed + random).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_branch_predictor;

    localparam int INDEX_BITS = 4;
    localparam int ENTRIES    = 1 << INDEX_BITS;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;
`endif

    branch_predictor #(.INDEX_BITS(INDEX_BITS)) dut (
        .clk         (clk),
        .reset       (reset),
        .if_pc       (if_pc),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .upd_pred    (upd_pred)
`ifdef BP_STATS_EN
        ,
        .stat_branches (stat_branches),
        .stat_mispred  (stat_mispred)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: table addressed by plain integer arithmetic
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    int unsigned m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    int unsigned m_branches;
    int unsigned m_mispred;

    function automatic int unsigned idx_of(input int unsigned pc);
        return (pc / 4) % ENTRIES;
    endfunction

    function automatic int unsigned tag_of(input int unsigned pc);
        return pc / (4 * ENTRIES);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 0;
            m_target[i] = 0;
            m_ctr[i]    = 1;
        end
        m_branches = 0;
        m_mispred  = 0;
    endfunction

    function automatic void model_pred(input int unsigned pc, output bit t, output int unsigned tgt);
        int unsigned i;
        i = idx_of(pc);
        t = m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
        tgt = t ? m_target[i] : pc + 32'd4;
    endfunction

    function automatic void model_update(input int unsigned pc, input bit tk,
                                         input int unsigned tgt, input bit pr);
        int unsigned i;
        i = idx_of(pc);
        m_branches++;
        if (pr != tk) m_mispred++;
        if (m_valid[i] && m_tag[i] == tag_of(pc)) begin
            if (tk) begin
                m_ctr[i]    = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                m_target[i] = tgt;
            end else begin
                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
        end else if (tk) begin
            m_valid[i]  = 1'b1;
            m_tag[i]    = tag_of(pc);
            m_target[i] = tgt;
            m_ctr[i]    = 2;
        end
    endfunction

    // One clock: drive at negedge, compare lookup against pre-edge model, advance
    task automatic cycle(input bit rst, input logic [31:0] ipc, input bit uv,
                         input logic [31:0] upc, input bit ut, input logic [31:0] utg,
                         input bit up);
        bit          e_t;
        int unsigned e_tgt;
        @(negedge clk);
        reset = rst; if_pc = ipc; upd_valid = uv; upd_pc = upc;
        upd_taken = ut; upd_target = utg; upd_pred = up;
        #1;
        model_pred(ipc, e_t, e_tgt);
        check("pred_taken", {31'd0, pred_taken}, {31'd0, e_t});
        check("pred_target", pred_target, e_tgt);
`ifdef BP_STATS_EN
        check("stat_branches", stat_branches, m_branches);
        check("stat_mispred", stat_mispred, m_mispred);
`endif
        @(posedge clk);
        if (rst) model_reset();
        else if (uv) model_update(upc, ut, utg, up);
    endtask

    task automatic expect_pred(input string tag, input logic [31:0] ipc,
                               input bit t, input logic [31:0] tgt);
        @(negedge clk);
        reset = 1'b0; if_pc = ipc; upd_valid = 1'b0;
        #1;
        check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, t});
        check({tag, "_target"}, pred_target, tgt);
    endtask

    localparam logic [31:0] PC_A   = 32'h0040_0010;
    localparam logic [31:0] PC_B   = 32'h0040_0050;
    localparam logic [31:0] TGT_A  = 32'h0040_0100;
    localparam logic [31:0] TGT_B  = 32'h0040_0200;

    initial begin
        reset = 1'b1; if_pc = '0; upd_valid = 1'b0; upd_pc = '0;
        upd_taken = 1'b0; upd_target = '0; upd_pred = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();

        // Cold table misses, including the 32-bit wrap of the fall-through
        expect_pred("reset_miss", PC_A, 1'b0, 32'h0040_0014);
        expect_pred("wrap_miss", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

        // Taken update allocates, visible next cycle
        cycle(0, PC_A, 1, PC_A, 1, TGT_A, 0);
        expect_pred("alloc_hit", PC_A, 1'b1, TGT_A);

        // Counter path 10 -> 11 -> 11 -> 11 -> 10 -> 01
        cycle(0, PC_A, 1, PC_A, 1, TGT_A, 1);
        cycle(0, PC_A, 1, PC_A, 1, TGT_A, 1);
        cycle(0, PC_A, 1, PC_A, 1, TGT_A, 1);
        expect_pred("sat_hi", PC_A, 1'b1, TGT_A);
        cycle(0, PC_A, 1, PC_A, 0, TGT_A, 1);
        expect_pred("ctr_10", PC_A, 1'b1, TGT_A);
        cycle(0, PC_A, 1, PC_A, 0, TGT_A, 1);
        expect_pred("ctr_01", PC_A, 1'b0, 32'h0040_0014);

        // Same-cycle lookup and update: old state now, new state next cycle
        @(negedge clk);
        if_pc = PC_A; upd_valid = 1; upd_pc = PC_A; upd_taken = 1;
        upd_target = TGT_A; upd_pred = 0;
        #1;
        check("bypass_now", {31'd0, pred_taken}, 32'd0);
        @(posedge clk);
        model_update(PC_A, 1, TGT_A, 0);
        expect_pred("bypass_next", PC_A, 1'b1, TGT_A);

        // Aliasing PC evicts the previous occupant
        cycle(0, PC_B, 1, PC_B, 1, TGT_B, 0);
        expect_pred("alias_old", PC_A, 1'b0, 32'h0040_0014);
        expect_pred("alias_new", PC_B, 1'b1, TGT_B);

        // Not-taken miss allocates nothing; upd_valid=0 changes nothing
        cycle(0, PC_A, 1, 32'h0040_0090, 0, TGT_A, 1);
        cycle(0, PC_A, 0, PC_B, 0, TGT_A, 1);
        expect_pred("nt_miss", 32'h0040_0090, 1'b0, 32'h0040_0094);
        expect_pred("no_strobe", PC_B, 1'b1, TGT_B);

        // Reset beats a simultaneous update
        cycle(1, PC_B, 1, PC_A, 1, TGT_A, 0);
        expect_pred("rst_pri_a", PC_A, 1'b0, 32'h0040_0014);
        expect_pred("rst_pri_b", PC_B, 1'b0, 32'h0040_0054);

`ifdef BP_STATS_EN
        cycle(0, PC_A, 1, PC_A, 1, TGT_A, 1);
        cycle(0, PC_A, 1, PC_B, 1, TGT_B, 0);
        cycle(0, PC_A, 1, PC_A, 0, TGT_A, 0);
        @(negedge clk);
        upd_valid = 0;
        #1;
        check("stats_branches_3", stat_branches, 32'd3);
        check("stats_mispred_1", stat_mispred, 32'd1);
        cycle(1, PC_A, 1, PC_A, 1, TGT_A, 0);
        @(negedge clk);
        reset = 0; upd_valid = 0;
        #1;
        check("stats_branches_rst", stat_branches, 32'd0);
        check("stats_mispred_rst", stat_mispred, 32'd0);
        expect_pred("stats_rst_empty", PC_B, 1'b0, 32'h0040_0054);
`endif

        // Random traffic over a small PC pool to force hits, aliasing and churn
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ipc, upc, utg;
            ipc = {$urandom_range(0, 2) == 0 ? 32'hFFFF_FFC0 : 32'h0040_0000}
                  | ($urandom_range(0, 3) << 6) | ($urandom_range(0, ENTRIES - 1) << 2)
                  | $urandom_range(0, 3);
            upc = (n % 3 == 0) ? ipc
                  : (32'h0040_0000 | ($urandom_range(0, 3) << 6)
                     | ($urandom_range(0, ENTRIES - 1) << 2) | $urandom_range(0, 3));
            utg = $urandom;
            cycle(($urandom_range(0, 199) == 0), ipc, $urandom_range(0, 1), upc,
                  $urandom_range(0, 2) != 0, utg, $urandom_range(0, 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
